tx_icv_gen: RTL and testbench

Transmit-side ICV generator for the CAN XL CANsec path. It computes a CBC-MAC over 1–16 128-bit payload blocks, chaining each block through an external AES-128 encryption engine. The truncated final ciphertext is delivered as the ICV to the frame builder. It is the counterpart of the receive-side ICV recomputation: both ends chain `block XOR previous_ciphertext` under the same key, so the receiver's result can be compared with the transmitted ICV.

---
 rtl/can_sec_pkg.sv | 24 ++
 rtl/tx_icv_gen.sv | 166 ++++++++++++++++
 tb/tb_tx_icv_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_sec_pkg.sv
// -----------------------------------------------------------------------------
// can_sec_pkg
// Shared constants and types for the CAN XL CANsec datapath.
//   AES_BLK_W : AES block width in bits
//   MAX_BLKS  : maximum number of 128-bit payload blocks per frame
//   ICV_W_DEF : default ICV width (MSBs of the final ciphertext)
//   CNT_W     : width of the block-count field
//   state_e   : ICV generator FSM states
// -----------------------------------------------------------------------------
package can_sec_pkg;

  localparam int AES_BLK_W = 128;
  localparam int MAX_BLKS  = 16;
  localparam int ICV_W_DEF = 64;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    ENC      = 2'd2,
    HOLD     = 2'd3
  } state_e;

endpackage

// File: rtl/tx_icv_gen.sv
// -----------------------------------------------------------------------------
// tx_icv_gen
// Transmit-side CBC-MAC ICV generator. Each payload block is XORed with the
// previous ciphertext (zero for the first block) and handed to an external
// AES-128 engine; the MSBs of the final ciphertext become the ICV.
//
// Ports
//   clk, g_rst        : clock, asynchronous active-high reset
//   tx_start          : one-cycle start pulse (sampled only in IDLE)
//   blk_count         : blocks in this frame, legal 1..MAX_BLKS
//   key               : AES key, latched on an accepted tx_start
//   blk_data/valid    : payload block input
//   blk_ready         : high in WAIT_BLK
//   aes_start         : one-cycle request to the AES engine
//   aes_key, aes_din  : latched key and registered block^chain
//   aes_dout/aes_done : ciphertext and its one-cycle completion strobe
//   tx_abort          : cancels any computation in progress
//   icv, icv_valid    : result, valid held until icv_ack
//   icv_ack           : result consumed
//   busy              : state != IDLE
//   err               : one-cycle pulse on an illegal blk_count
//   dbg_state         : current FSM state, for observation
//
// Handshake: a block transfers on a rising clk edge where blk_valid and
// blk_ready are both high. blk_valid may be raised at any time; blk_ready
// does not depend on blk_valid. A block offered outside WAIT_BLK is left
// untouched and is taken once WAIT_BLK is reached, if still offered.
// -----------------------------------------------------------------------------
module tx_icv_gen
  import can_sec_pkg::*;
#(
  parameter int ICV_W    = ICV_W_DEF,
  parameter int MAX_BLKS = can_sec_pkg::MAX_BLKS
) (
  input  logic                 clk,
  input  logic                 g_rst,
  input  logic                 tx_start,
  input  logic [CNT_W-1:0]     blk_count,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [AES_BLK_W-1:0] blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic                 aes_start,
  output logic [AES_BLK_W-1:0] aes_key,
  output logic [AES_BLK_W-1:0] aes_din,
  input  logic [AES_BLK_W-1:0] aes_dout,
  input  logic                 aes_done,
  input  logic                 tx_abort,
  output logic [ICV_W-1:0]     icv,
  output logic                 icv_valid,
  input  logic                 icv_ack,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_BLK = WAIT_BLK;
  localparam logic [1:0] ST_ENC      = ENC;
  localparam logic [1:0] ST_HOLD     = HOLD;

  logic [1:0]           r_state;
  logic [AES_BLK_W-1:0] r_chain;
  logic [CNT_W-1:0]     r_remaining;
  logic [AES_BLK_W-1:0] r_key;
  logic [AES_BLK_W-1:0] r_din;
  logic                 r_aes_start;
  logic [ICV_W-1:0]     r_icv;
  logic                 r_icv_valid;
  logic                 r_err;

  logic w_blk_ready;
  logic w_accept;
  logic w_cnt_ok;
  logic w_abort;

  assign w_blk_ready = (r_state == ST_WAIT_BLK);
  assign w_accept    = blk_valid & w_blk_ready;
  assign w_cnt_ok    = (blk_count != '0) && (int'(blk_count) <= MAX_BLKS);
  // Abort only has an effect once a computation is in flight.
  assign w_abort     = tx_abort && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_state     <= ST_IDLE;
      r_chain     <= '0;
      r_remaining <= '0;
      r_key       <= '0;
      r_din       <= '0;
      r_aes_start <= 1'b0;
      r_icv       <= '0;
      r_icv_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Both strobes are single-cycle by construction.
      r_aes_start <= 1'b0;
      r_err       <= 1'b0;

      if (w_abort) begin
        // Dropping to IDLE also makes any late aes_done harmless.
        r_state     <= ST_IDLE;
        r_icv_valid <= 1'b0;
        r_chain     <= '0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (tx_start && !tx_abort) begin
              if (w_cnt_ok) begin
                r_chain     <= '0;
                r_remaining <= blk_count;
                r_key       <= key;
                r_state     <= ST_WAIT_BLK;
              end else begin
                r_err <= 1'b1;
              end
            end
          end

          ST_WAIT_BLK: begin
            if (w_accept) begin
              r_din       <= blk_data ^ r_chain;
              r_aes_start <= 1'b1;
              r_state     <= ST_ENC;
            end
          end

          ST_ENC: begin
            if (aes_done) begin
              r_chain     <= aes_dout;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == 5'd1) begin
                r_icv       <= aes_dout[AES_BLK_W-1 -: ICV_W];
                r_icv_valid <= 1'b1;
                r_state     <= ST_HOLD;
              end else begin
                r_state <= ST_WAIT_BLK;
              end
            end
          end

          ST_HOLD: begin
            // icv itself is left untouched so the last result stays readable.
            if (icv_ack) begin
              r_icv_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign blk_ready = w_blk_ready;
  assign aes_start = r_aes_start;
  assign aes_key   = r_key;
  assign aes_din   = r_din;
  assign icv       = r_icv;
  assign icv_valid = r_icv_valid;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tx_icv_gen.sv
module tb_tx_icv_gen;
  import can_sec_pkg::*;

  localparam int TB_ICV_W = 64;

  localparam logic [127:0] K_FIPS   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_FIPS   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  ICV_FIPS = 64'h69c4e0d86a7b0430;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] B2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] B3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                g_rst;
  logic                tx_start;
  logic [4:0]          blk_count;
  logic [127:0]        key;
  logic [127:0]        blk_data;
  logic                blk_valid;
  logic                blk_ready;
  logic                aes_start;
  logic [127:0]        aes_key;
  logic [127:0]        aes_din;
  logic [127:0]        aes_dout;
  logic                aes_done;
  logic                tx_abort;
  logic [TB_ICV_W-1:0] icv;
  logic                icv_valid;
  logic                icv_ack;
  logic                busy;
  logic                err;
  logic [1:0]          dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tx_icv_gen #(.ICV_W(TB_ICV_W), .MAX_BLKS(16)) dut (
    .clk(clk), .g_rst(g_rst), .tx_start(tx_start), .blk_count(blk_count),
    .key(key), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .aes_start(aes_start), .aes_key(aes_key), .aes_din(aes_din),
    .aes_dout(aes_dout), .aes_done(aes_done), .tx_abort(tx_abort),
    .icv(icv), .icv_valid(icv_valid), .icv_ack(icv_ack), .busy(busy),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, t, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      t = inv; s = inv;
      for (int r = 0; r < 4; r++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
          st[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          st[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) st[i] = tmp[i];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Behavioural AES engine: done 12 cycles after each start; keeps running
  // through abort/reset so a late done really reaches the DUT.
  initial begin : aes_model
    logic [127:0] lk, ld;
    aes_done = 1'b0;
    aes_dout = '0;
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) begin
        n_starts++;
        lk = aes_key;
        ld = aes_din;
        if (exp_q.size() == 0) check_eq("aes_start_unexpected", 128'd1, 128'd0);
        else check_eq("aes_din", ld, exp_q.pop_front());
        repeat (12) @(posedge clk);
        #1;
        aes_dout = aes_enc(lk, ld);
        aes_done = 1'b1;
        @(posedge clk);
        #1 aes_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [4:0] cnt, input logic [127:0] k);
    @(negedge clk);
    tx_start = 1'b1; blk_count = cnt; key = k;
    @(negedge clk);
    tx_start = 1'b0; blk_count = '0; key = '0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (blk_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check_eq("blk_ready_timeout", 128'd0, 128'd1);
  endtask

  task automatic send_block(input logic [127:0] data);
    @(negedge clk);
    wait_ready();
    blk_valid = 1'b1; blk_data = data;
    @(posedge clk);
    #1 blk_valid = 1'b0; blk_data = '0;
    @(negedge clk);
    check_eq("aes_start_after_accept", {127'd0, aes_start}, 128'd1);
    @(negedge clk);
    check_eq("aes_start_one_cycle", {127'd0, aes_start}, 128'd0);
  endtask

  task automatic wait_icv();
    int t;
    t = 0;
    while (icv_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check_eq("icv_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic ack_icv();
    @(negedge clk);
    icv_ack = 1'b1;
    @(negedge clk);
    icv_ack = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [127:0] c1, c2, c3;
    int s0, bp_ok;
    g_rst = 1'b1; tx_start = 1'b0; blk_count = '0; key = '0;
    blk_data = '0; blk_valid = 1'b0; tx_abort = 1'b0; icv_ack = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_icv", {64'd0, icv}, 128'd0);
    check_eq("rst_flags", {120'd0, icv_valid, blk_ready, aes_start, busy, err, 3'd0}, 128'd0);
    check_eq("rst_aes_din", aes_din, 128'd0);
    check_eq("rst_aes_key", aes_key, 128'd0);
    check_eq("rst_state", {126'd0, dbg_state}, 128'(IDLE));
    g_rst = 1'b0;

    // Single block, FIPS-197 vector
    exp_q.push_back(P_FIPS);
    s0 = n_starts;
    start_frame(5'd1, K_FIPS);
    check_eq("fips_busy", {127'd0, busy}, 128'd1);
    check_eq("fips_blk_ready", {127'd0, blk_ready}, 128'd1);
    check_eq("fips_aes_key", aes_key, K_FIPS);
    send_block(P_FIPS);
    wait_icv();
    check_eq("fips_icv", {64'd0, icv}, {64'd0, ICV_FIPS});
    repeat (3) @(negedge clk);
    check_eq("fips_icv_valid_held", {127'd0, icv_valid}, 128'd1);
    check_eq("fips_state_hold", {126'd0, dbg_state}, 128'(HOLD));
    ack_icv();
    check_eq("fips_icv_valid_after_ack", {127'd0, icv_valid}, 128'd0);
    check_eq("fips_busy_after_ack", {127'd0, busy}, 128'd0);
    check_eq("fips_icv_kept", {64'd0, icv}, {64'd0, ICV_FIPS});
    check_eq("fips_start_count", 128'(n_starts - s0), 128'd1);

    // Three-block chaining with backpressure before block 2
    c1 = aes_enc(K2, B1);
    c2 = aes_enc(K2, B2 ^ c1);
    c3 = aes_enc(K2, B3 ^ c2);
    exp_q.push_back(B1);
    exp_q.push_back(B2 ^ c1);
    exp_q.push_back(B3 ^ c2);
    s0 = n_starts;
    start_frame(5'd3, K2);
    send_block(B1);
    wait_ready();
    bp_ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (blk_ready === 1'b1 && aes_start === 1'b0) bp_ok++;
    end
    check_eq("backpressure_ready_no_start", 128'(bp_ok), 128'd5);
    send_block(B2);
    send_block(B3);
    wait_icv();
    check_eq("chain3_icv", {64'd0, icv}, {64'd0, c3[127:64]});
    check_eq("chain3_start_count", 128'(n_starts - s0), 128'd3);
    ack_icv();

    // Abort during encryption of block 2
    c1 = aes_enc(K_FIPS, P_FIPS);
    exp_q.push_back(P_FIPS);
    exp_q.push_back(B2 ^ c1);
    start_frame(5'd3, K_FIPS);
    send_block(P_FIPS);
    send_block(B2);
    repeat (3) @(negedge clk);
    check_eq("abort_in_enc", {126'd0, dbg_state}, 128'(ENC));
    tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    check_eq("abort_busy", {127'd0, busy}, 128'd0);
    check_eq("abort_ready_valid", {126'd0, blk_ready, icv_valid}, 128'd0);
    repeat (20) @(negedge clk);
    check_eq("late_done_ignored", {126'd0, busy, icv_valid}, 128'd0);
    exp_q.push_back(P_FIPS);
    start_frame(5'd1, K_FIPS);
    send_block(P_FIPS);
    wait_icv();
    check_eq("post_abort_icv", {64'd0, icv}, {64'd0, ICV_FIPS});

    // tx_start during HOLD is ignored
    start_frame(5'd1, K2);
    check_eq("hold_start_icv_valid", {127'd0, icv_valid}, 128'd1);
    check_eq("hold_start_key", aes_key, K_FIPS);
    check_eq("hold_start_err", {127'd0, err}, 128'd0);
    check_eq("hold_start_icv", {64'd0, icv}, {64'd0, ICV_FIPS});

    // Abort and ack together: abort path wins
    @(negedge clk);
    tx_abort = 1'b1; icv_ack = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0; icv_ack = 1'b0;
    check_eq("abort_ack_flags", {126'd0, icv_valid, busy}, 128'd0);

    // Illegal counts and the upper legal boundary
    start_frame(5'd0, K2);
    check_eq("cnt0_err", {127'd0, err}, 128'd1);
    check_eq("cnt0_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check_eq("cnt0_err_one_cycle", {127'd0, err}, 128'd0);
    start_frame(5'd17, K2);
    check_eq("cnt17_err", {127'd0, err}, 128'd1);
    check_eq("cnt17_busy", {127'd0, busy}, 128'd0);
    start_frame(5'd16, K2);
    check_eq("cnt16_err", {127'd0, err}, 128'd0);
    check_eq("cnt16_busy", {127'd0, busy}, 128'd1);
    @(negedge clk);
    tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    check_eq("cnt16_abort_idle", {127'd0, busy}, 128'd0);

    // Asynchronous reset while in ENC
    exp_q.push_back(P_FIPS);
    start_frame(5'd1, K_FIPS);
    send_block(P_FIPS);
    repeat (2) @(negedge clk);
    check_eq("rst_mid_in_enc", {126'd0, dbg_state}, 128'(ENC));
    #2 g_rst = 1'b1;
    #1;
    check_eq("rst_mid_flags", {123'd0, icv_valid, blk_ready, aes_start, busy, err}, 128'd0);
    check_eq("rst_mid_icv", {64'd0, icv}, 128'd0);
    check_eq("rst_mid_aes_din", aes_din, 128'd0);
    check_eq("rst_mid_aes_key", aes_key, 128'd0);
    repeat (3) @(negedge clk);
    g_rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_state_idle", {126'd0, dbg_state}, 128'(IDLE));
    check_eq("rst_mid_busy", {127'd0, busy}, 128'd0);

    // Recovery after reset
    exp_q.push_back(P_FIPS);
    start_frame(5'd1, K_FIPS);
    send_block(P_FIPS);
    wait_icv();
    check_eq("post_rst_icv", {64'd0, icv}, {64'd0, ICV_FIPS});
    ack_icv();

    repeat (2) @(negedge clk);
    check_eq("exp_q_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
